// File: rtl/auxcmd_membank_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// auxcmd_pkg
// Shared constants and types for the aux-command RAM write arbiter.
//   AUXCMD_NUM_BANKS : number of Xillybus write streams / RAM banks
//   AUXCMD_ADDR_W    : RAM word address width
//   AUXCMD_DATA_W    : Xillybus data width
//   AUXCMD_BANK_W    : bank index width
//   auxcmd_wr_t      : one queued RAM write {addr, data}
//   auxcmd_rr_next   : round-robin successor of an index
// ---------------------------------------------------------------------------
package auxcmd_pkg;

    localparam int AUXCMD_NUM_BANKS = 3;
    localparam int AUXCMD_ADDR_W    = 10;
    localparam int AUXCMD_DATA_W    = 16;
    localparam int AUXCMD_XADDR_W   = 16;
    localparam int AUXCMD_BANK_W    = (AUXCMD_NUM_BANKS > 1) ? $clog2(AUXCMD_NUM_BANKS) : 1;

    typedef struct packed {
        logic [AUXCMD_ADDR_W-1:0] addr;
        logic [AUXCMD_DATA_W-1:0] data;
    } auxcmd_wr_t;

    // Successor modulo n; n need not be a power of two.
    function automatic int auxcmd_rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/auxcmd_membank_arbiter_if.sv
// ---------------------------------------------------------------------------
// auxcmd_membank_arbiter_if
// Bundles the Xillybus write-stream side and the RAM write-port side of the
// arbiter.
//   quiesce          : link down, synchronous flush
//   req_wren/data    : per-stream write strobe and data
//   req_open         : per-stream open status
//   req_addr/_update : per-stream seek address and load strobe
//   req_full         : per-stream backpressure
//   ram_wr_ready     : RAM port accepts a write this cycle
//   ram_wr_en/bank/addr/data : registered RAM write
//   busy, oob_err    : status
// modport master = stream/RAM environment, modport slave = arbiter.
// ---------------------------------------------------------------------------
interface auxcmd_membank_arbiter_if
    import auxcmd_pkg::*;
#(
    parameter int NUM_REQ = AUXCMD_NUM_BANKS,
    parameter int DATA_W  = AUXCMD_DATA_W,
    parameter int ADDR_W  = AUXCMD_ADDR_W
);
    localparam int BANK_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                                     quiesce;
    logic [NUM_REQ-1:0]                       req_wren;
    logic [NUM_REQ-1:0][DATA_W-1:0]           req_data;
    logic [NUM_REQ-1:0]                       req_open;
    logic [NUM_REQ-1:0][AUXCMD_XADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]                       req_addr_update;
    logic [NUM_REQ-1:0]                       req_full;
    logic                                     ram_wr_ready;
    logic                                     ram_wr_en;
    logic [BANK_W-1:0]                        ram_wr_bank;
    logic [ADDR_W-1:0]                        ram_wr_addr;
    logic [DATA_W-1:0]                        ram_wr_data;
    logic                                     busy;
    logic [NUM_REQ-1:0]                       oob_err;

    modport master (
        output quiesce, req_wren, req_data, req_open, req_addr, req_addr_update, ram_wr_ready,
        input  req_full, ram_wr_en, ram_wr_bank, ram_wr_addr, ram_wr_data, busy, oob_err
    );

    modport slave (
        input  quiesce, req_wren, req_data, req_open, req_addr, req_addr_update, ram_wr_ready,
        output req_full, ram_wr_en, ram_wr_bank, ram_wr_addr, ram_wr_data, busy, oob_err
    );

endinterface

// File: rtl/auxcmd_membank_arbiter_req_fifo.sv
// ---------------------------------------------------------------------------
// auxcmd_req_fifo
// Small per-stream FIFO of pending RAM writes (auxcmd_wr_t entries).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : synchronous empty
//   push_i/din_i : enqueue
//   pop_i/dout_o : dequeue, dout_o shows the head entry (first-word fall-through)
//   count_o      : occupancy, empty_o : count_o == 0
// Push and pop in the same cycle are both honoured, even when full.
// ---------------------------------------------------------------------------
module auxcmd_req_fifo
    import auxcmd_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  auxcmd_wr_t       din_i,
    input  logic             pop_i,
    output auxcmd_wr_t       dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    auxcmd_wr_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap on overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/auxcmd_membank_arbiter.sv
// ---------------------------------------------------------------------------
// auxcmd_membank_arbiter
// Shares the single aux-command RAM write port among NUM_REQ Xillybus
// seekable write streams. Each stream has an address counter and a small
// FIFO; the RAM port is granted round-robin, one write per cycle, and the
// write is registered one edge after the grant.
//   bus_clk : PCIe user clock (all logic)
//   reset   : asynchronous, active-high
//   bus     : auxcmd_membank_arbiter_if.slave (stream side + RAM side)
// Optional feature: define AUXCMD_ARB_BOUNDS_CHECK_EN to drop writes whose
// address is >= BANK_DEPTH and flag them in a sticky oob_err bit per stream.
// Without it oob_err is 0 and every address is written modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module auxcmd_membank_arbiter
    import auxcmd_pkg::*;
#(
    parameter int NUM_REQ    = AUXCMD_NUM_BANKS,
    parameter int DATA_W     = AUXCMD_DATA_W,
    parameter int ADDR_W     = AUXCMD_ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int BANK_DEPTH = 1024
) (
    input  logic                      bus_clk,
    input  logic                      reset,
    auxcmd_membank_arbiter_if.slave   bus
);
    localparam int BANK_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_q, addr_d, tag_addr;
    logic [NUM_REQ-1:0]             full, accept, push, pop, empty, oob_hit;
    logic [NUM_REQ-1:0][CNT_W-1:0]  count;
    auxcmd_wr_t [NUM_REQ-1:0]       fifo_in, fifo_out;
    auxcmd_wr_t                     gnt_entry;

    logic [BANK_W-1:0] rr_q, rr_d, gnt_idx;
    logic              gnt_vld;

    logic              wr_en_q;
    logic [BANK_W-1:0] wr_bank_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // req_open is status only: closing a stream neither flushes nor moves
    // its counter. Only the low ADDR_W bits of the seek address are used.
    logic unused_in;
    assign unused_in = ^{bus.req_open, bus.req_addr};

    // ---------------- round-robin grant ----------------
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        if (bus.ram_wr_ready && !bus.quiesce) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_vld && !empty[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = BANK_W'(idx);
                end
            end
        end
        rr_d = gnt_vld ? BANK_W'(auxcmd_rr_next(int'(gnt_idx), NUM_REQ)) : rr_q;
    end

    always_comb begin
        gnt_entry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = gnt_vld && (gnt_idx == BANK_W'(i));
            if (pop[i]) gnt_entry = fifo_out[i];
        end
    end

    // ---------------- per-stream accept / address counter ----------------
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            // full looks through this cycle's pop so a lone stream can
            // push every cycle while its head drains.
            full[i]     = (count[i] == CNT_W'(FIFO_DEPTH)) && !pop[i] && !bus.quiesce;
            accept[i]   = bus.req_wren[i] && !full[i] && !bus.quiesce;
            // A coincident seek takes effect for this very write.
            tag_addr[i] = bus.req_addr_update[i] ? bus.req_addr[i][ADDR_W-1:0] : addr_q[i];
            addr_d[i]   = tag_addr[i];
            if (accept[i]) addr_d[i] = tag_addr[i] + ADDR_W'(1);
`ifdef AUXCMD_ARB_BOUNDS_CHECK_EN
            oob_hit[i]  = 32'(tag_addr[i]) >= 32'(BANK_DEPTH);
`else
            oob_hit[i]  = 1'b0;
`endif
            push[i]       = accept[i] && !oob_hit[i];
            fifo_in[i]    = '{addr: tag_addr[i], data: bus.req_data[i]};
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        auxcmd_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (bus_clk),
            .rst_i   (reset),
            .flush_i (bus.quiesce),
            .push_i  (push[g]),
            .din_i   (fifo_in[g]),
            .pop_i   (pop[g]),
            .dout_o  (fifo_out[g]),
            .count_o (count[g]),
            .empty_o (empty[g])
        );
    end

    // ---------------- state + output register ----------------
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            rr_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (bus.quiesce) begin
            addr_q  <= '0;
            rr_q    <= '0;
            wr_en_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rr_q    <= rr_d;
            wr_en_q <= gnt_vld;
            if (gnt_vld) begin
                wr_bank_q <= gnt_idx;
                wr_addr_q <= gnt_entry.addr;
                wr_data_q <= gnt_entry.data;
            end
        end
    end

`ifdef AUXCMD_ARB_BOUNDS_CHECK_EN
    logic [NUM_REQ-1:0] oob_q, oob_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            oob_d[i] = oob_q[i] && !bus.req_addr_update[i];
            if (accept[i] && oob_hit[i]) oob_d[i] = 1'b1;
        end
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset)            oob_q <= '0;
        else if (bus.quiesce) oob_q <= '0;
        else                  oob_q <= oob_d;
    end

    assign bus.oob_err = oob_q;
`else
    localparam int UNUSED_BANK_DEPTH = BANK_DEPTH;
    assign bus.oob_err = '0;
`endif

    assign bus.req_full    = full;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_bank = wr_bank_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;
    assign bus.busy        = (~empty != '0) || wr_en_q;

endmodule

// File: tb/tb_auxcmd_membank_arbiter.sv
module tb_auxcmd_membank_arbiter;
    import auxcmd_pkg::*;

    localparam int N = 3;
`ifdef AUXCMD_ARB_BOUNDS_CHECK_EN
    localparam int BD = 512;
`else
    localparam int BD = 1024;
`endif

    typedef struct packed { logic [9:0] addr; logic [15:0] data; } exp_t;

    logic bus_clk = 1'b0;
    logic reset   = 1'b0;
    always #5 bus_clk = ~bus_clk;

    auxcmd_membank_arbiter_if #(.NUM_REQ(N), .DATA_W(16), .ADDR_W(10)) bus ();

    auxcmd_membank_arbiter #(
        .NUM_REQ(N), .DATA_W(16), .ADDR_W(10), .FIFO_DEPTH(2), .BANK_DEPTH(BD)
    ) dut (
        .bus_clk (bus_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t sbq [N][$];
    logic [9:0]  maddr [N];
    logic [15:0] mdata [N];
    int          wr_bank [$];
    int          wr_cyc  [$];
    logic [9:0]  wr_addr [$];
    int          last_bank = N - 1;
    int          pushed    = 0;
    logic [N-1:0] full_seen;
    logic        mon_en = 1'b0;

    always @(posedge bus_clk) cyc++;

    // Scoreboard: every RAM write must match the head of its bank's queue.
    always @(negedge bus_clk) begin : mon
        exp_t e;
        int b;
        if (mon_en && !reset) begin
            full_seen = full_seen | bus.req_full;
            if (bus.ram_wr_en) begin
                b = int'(bus.ram_wr_bank);
                wr_bank.push_back(b);
                wr_cyc.push_back(cyc);
                wr_addr.push_back(bus.ram_wr_addr);
                last_bank = b;
                checks++;
                if (b >= N || sbq[b].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write bank=%0d addr=%h data=%h", b, bus.ram_wr_addr, bus.ram_wr_data);
                end else begin
                    e = sbq[b].pop_front();
                    if ({bus.ram_wr_addr, bus.ram_wr_data} !== e) begin
                        errors++;
                        $display("FAIL write_bank%0d got addr=%h data=%h want addr=%h data=%h",
                                 b, bus.ram_wr_addr, bus.ram_wr_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += sbq[i].size();
        return s;
    endfunction

    task automatic clear_log();
        wr_bank.delete(); wr_cyc.delete(); wr_addr.delete();
        full_seen = '0;
        pushed    = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sbq[i].delete();
            maddr[i] = '0;
        end
        last_bank = N - 1;
    endtask

    // Called at posedge+1. Behaves like the Xillybus core: only strobes
    // wren on streams whose full flag is low.
    task automatic drive(input logic [N-1:0] want, input logic rdy);
        bus.ram_wr_ready = rdy;
        #1;
        for (int i = 0; i < N; i++) begin
            bus.req_wren[i] = want[i] & ~bus.req_full[i];
            bus.req_data[i] = mdata[i];
            if (bus.req_wren[i]) begin
                if (int'(maddr[i]) < BD) begin
                    sbq[i].push_back('{maddr[i], mdata[i]});
                    pushed++;
                end
                maddr[i] = maddr[i] + 10'd1;
                mdata[i] = mdata[i] + 16'd1;
            end
        end
        @(posedge bus_clk); #1;
        bus.req_wren = '0;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        bus.req_addr_update[i] = 1'b1;
        bus.req_addr[i]        = {6'd0, a};
        maddr[i]               = a;
        @(posedge bus_clk); #1;
        bus.req_addr_update = '0;
    endtask

    task automatic drain();
        int n = 0;
        bus.ram_wr_ready = 1'b1;
        bus.req_wren     = '0;
        while ((pending() != 0 || bus.busy) && n < 60) begin
            @(posedge bus_clk); #1;
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%b want pending=0 busy=0", pending(), bus.busy);
        end
    endtask

    task automatic check_rotation(input string name, input int first);
        int bad = 0;
        for (int k = 1; k < wr_bank.size(); k++)
            if (wr_bank[k] != (wr_bank[k-1] + 1) % N) bad++;
        checks++;
        if (wr_bank.size() == 0 || wr_bank[0] != first || bad != 0) begin
            errors++;
            $display("FAIL %s_order first=%0d out_of_order=%0d want first=%0d out_of_order=0",
                     name, (wr_bank.size() != 0) ? wr_bank[0] : -1, bad, first);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (bus.ram_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.req_full !== '0 || bus.oob_err !== '0 ||
            bus.ram_wr_bank !== '0 || bus.ram_wr_addr !== '0 || bus.ram_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs en=%b busy=%b full=%b oob=%b bank=%0d addr=%h data=%h want all 0",
                     bus.ram_wr_en, bus.busy, bus.req_full, bus.oob_err, bus.ram_wr_bank, bus.ram_wr_addr, bus.ram_wr_data);
        end
        repeat (2) @(posedge bus_clk);
        #2 reset = 1'b0;
        @(posedge bus_clk); #1;
        mon_en = 1'b1;
        model_reset();
        repeat (3) drive('0, 1'b1);
        checks++;
        if (bus.ram_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset en=%b busy=%b want 0 0", bus.ram_wr_en, bus.busy);
        end
    endtask

    task automatic test_single_stream();
        set_addr(0, 10'h005);
        mdata[0] = 16'h00A0;
        clear_log();
        drive(3'b001, 1'b1);
        checks++;
        if (bus.ram_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL latency_early en=%b want 0", bus.ram_wr_en);
        end
        drive(3'b001, 1'b1);
        checks++;
        if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 10'h005 || bus.ram_wr_data !== 16'h00A0) begin
            errors++;
            $display("FAIL latency_first en=%b addr=%h data=%h want 1 005 00a0", bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data);
        end
        drive(3'b001, 1'b1);
        drive(3'b001, 1'b1);
        drain();
        checks++;
        if (wr_bank.size() != 4 || wr_cyc[wr_cyc.size()-1] - wr_cyc[0] != 3 || full_seen[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_stream writes=%0d full_seen=%b want 4 consecutive, full 0", wr_bank.size(), full_seen[0]);
        end
    endtask

    task automatic test_saturate();
        int first;
        first = (last_bank + 1) % N;
        for (int i = 0; i < N; i++) mdata[i] = 16'h1000 * (i + 1);
        clear_log();
        repeat (24) drive('1, 1'b1);
        drain();
        checks++;
        if (full_seen !== '1) begin
            errors++;
            $display("FAIL saturate_full full_seen=%b want 111", full_seen);
        end
        checks++;
        if (wr_bank.size() != pushed || wr_cyc[wr_cyc.size()-1] - wr_cyc[0] != pushed - 1) begin
            errors++;
            $display("FAIL saturate_count writes=%0d want %0d back to back", wr_bank.size(), pushed);
        end
        check_rotation("saturate", first);
    endtask

    task automatic test_ready_stall();
        int first;
        first = (last_bank + 1) % N;
        clear_log();
        drive('1, 1'b0);
        drive('1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.req_full !== '1 || bus.ram_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d full=%b en=%b want 111 0", c, bus.req_full, bus.ram_wr_en);
            end
            drive('0, 1'b0);
        end
        drain();
        checks++;
        if (wr_bank.size() != 6) begin
            errors++;
            $display("FAIL stall_count writes=%0d want 6", wr_bank.size());
        end
        check_rotation("stall", first);
    endtask

    task automatic test_wrap();
        set_addr(2, 10'h3FF);
        clear_log();
        drive(3'b100, 1'b1);
        drive(3'b100, 1'b1);
        drain();
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 10'h3FF || wr_addr[1] !== 10'h000) begin
            errors++;
            $display("FAIL wrap writes=%0d addr0=%h addr1=%h want 2 3ff 000", wr_addr.size(),
                     (wr_addr.size() > 0) ? wr_addr[0] : 10'h0, (wr_addr.size() > 1) ? wr_addr[1] : 10'h0);
        end
    endtask

    task automatic test_addr_coincident();
        clear_log();
        bus.ram_wr_ready       = 1'b1;
        bus.req_addr_update[1] = 1'b1;
        bus.req_addr[1]        = 16'hF123;   // upper bits are ignored
        bus.req_wren[1]        = 1'b1;
        bus.req_data[1]        = mdata[1];
        sbq[1].push_back('{10'h123, mdata[1]});
        maddr[1] = 10'h124;
        mdata[1] = mdata[1] + 16'd1;
        @(posedge bus_clk); #1;
        bus.req_addr_update = '0;
        bus.req_wren        = '0;
        drive(3'b010, 1'b1);
        drain();
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 10'h123 || wr_addr[1] !== 10'h124) begin
            errors++;
            $display("FAIL coincident_update writes=%0d want addr 123 then 124", wr_addr.size());
        end
    endtask

    task automatic test_quiesce();
        drive('1, 1'b0);
        drive('1, 1'b0);
        bus.quiesce  = 1'b1;
        bus.req_wren = '1;
        @(posedge bus_clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.ram_wr_en !== 1'b0 || bus.req_full !== '0) begin
            errors++;
            $display("FAIL quiesce_flush busy=%b en=%b full=%b want 0 0 000", bus.busy, bus.ram_wr_en, bus.req_full);
        end
        bus.quiesce  = 1'b0;
        bus.req_wren = '0;
        model_reset();
        clear_log();
        repeat (4) drive('0, 1'b1);
        checks++;
        if (wr_bank.size() != 0) begin
            errors++;
            $display("FAIL quiesce_leak writes=%0d want 0", wr_bank.size());
        end
        drive('1, 1'b1);
        drain();
        checks++;
        if (wr_addr.size() != 3 || wr_addr[0] !== 10'h000 || wr_addr[2] !== 10'h000) begin
            errors++;
            $display("FAIL quiesce_restart writes=%0d want 3 at addr 000", wr_addr.size());
        end
        check_rotation("quiesce", 0);
    endtask

    task automatic test_reset_mid();
        drive('1, 1'b0);
        drive('1, 1'b0);
        bus.ram_wr_ready = 1'b1;
        @(posedge bus_clk); #1;
        checks++;
        if (bus.ram_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre en=%b want 1", bus.ram_wr_en);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.ram_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.req_full !== '0 ||
            bus.ram_wr_addr !== '0 || bus.ram_wr_data !== '0 || bus.ram_wr_bank !== '0) begin
            errors++;
            $display("FAIL reset_mid en=%b busy=%b full=%b addr=%h data=%h want all 0",
                     bus.ram_wr_en, bus.busy, bus.req_full, bus.ram_wr_addr, bus.ram_wr_data);
        end
        @(posedge bus_clk); #2 reset = 1'b0;
        @(posedge bus_clk); #1;
        model_reset();
        clear_log();
        drive(3'b010, 1'b1);
        drain();
        checks++;
        if (wr_bank.size() != 1 || wr_addr[0] !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_restart writes=%0d want 1 at addr 000", wr_bank.size());
        end
    endtask

`ifdef AUXCMD_ARB_BOUNDS_CHECK_EN
    task automatic test_bounds();
        set_addr(1, 10'h200);
        clear_log();
        drive(3'b010, 1'b1);
        repeat (3) begin
            checks++;
            if (bus.ram_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL oob_write en=%b want 0", bus.ram_wr_en);
            end
            drive('0, 1'b1);
        end
        checks++;
        if (bus.oob_err !== 3'b010) begin
            errors++;
            $display("FAIL oob_set oob_err=%b want 010", bus.oob_err);
        end
        set_addr(1, 10'h000);
        checks++;
        if (bus.oob_err !== 3'b000) begin
            errors++;
            $display("FAIL oob_clear oob_err=%b want 000", bus.oob_err);
        end
        drive(3'b010, 1'b1);
        drain();
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'h000) begin
            errors++;
            $display("FAIL oob_recover writes=%0d want 1 at addr 000", wr_addr.size());
        end
    endtask
`endif

    initial begin
        bus.quiesce         = 1'b0;
        bus.req_wren        = '0;
        bus.req_data        = '0;
        bus.req_open        = '1;
        bus.req_addr        = '0;
        bus.req_addr_update = '0;
        bus.ram_wr_ready    = 1'b0;
        for (int i = 0; i < N; i++) mdata[i] = '0;
        model_reset();
        clear_log();
        #1;
        test_reset();
        test_single_stream();
        test_saturate();
        test_ready_stall();
`ifndef AUXCMD_ARB_BOUNDS_CHECK_EN
        test_wrap();
`endif
        test_addr_coincident();
        test_quiesce();
        test_reset_mid();
`ifdef AUXCMD_ARB_BOUNDS_CHECK_EN
        test_bounds();
`else
        checks++;
        if (bus.oob_err !== '0) begin
            errors++;
            $display("FAIL oob_tied oob_err=%b want 000", bus.oob_err);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
